// File: rtl/mandel_pixel_scheduler.sv
// Mandelbrot frame scheduler: walks the raster, hands pixels to free
// engines round-robin and turns engine results into framebuffer writes.
module mandel_pixel_scheduler #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int NUM_ENG = 4,
  parameter int ENG_W   = 2,
  parameter int ITER_W  = 8,
  parameter int ADDR_W  = 19
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [NUM_ENG-1:0]        disp_ready,
  output logic                      disp_valid,
  output logic [ENG_W-1:0]          disp_eng,
  output logic [15:0]               pix_x,
  output logic [15:0]               pix_y,
  input  logic [NUM_ENG-1:0]        res_valid,
  input  logic [NUM_ENG*ITER_W-1:0] res_iter,
  output logic [NUM_ENG-1:0]        res_ack,
  output logic                      fb_we,
  output logic [ADDR_W-1:0]         fb_addr,
  output logic [ITER_W-1:0]         fb_data,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int NP = 1 << ENG_W;
  localparam logic [15:0] X_LAST = 16'(H_RES - 1);
  localparam logic [15:0] Y_LAST = 16'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         x_q, x_d;
  logic [15:0]         y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_ENG-1:0]  eng_busy_q, eng_busy_d;
  logic                abort_q, abort_d;
  logic [ENG_W-1:0]    dptr_q, dptr_d;
  logic [ENG_W-1:0]    cptr_q, cptr_d;
  logic [ADDR_W-1:0]   addr_tab_q [NP];
  logic [ADDR_W-1:0]   addr_tab_d [NP];

  logic                disp_valid_q, disp_valid_d;
  logic [ENG_W-1:0]    disp_eng_q, disp_eng_d;
  logic [15:0]         pix_x_q, pix_x_d;
  logic [15:0]         pix_y_q, pix_y_d;
  logic [NUM_ENG-1:0]  res_ack_q, res_ack_d;
  logic                fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
  logic [ITER_W-1:0]   fb_data_q, fb_data_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;

  logic [NP-1:0]       elig, cand;
  logic                d_found, c_found;
  logic [ENG_W-1:0]    d_win, c_win;
  logic [ENG_W-1:0]    di, ci;
  int                  dj, cj;
  logic                last_pix, mid, drained;
  logic                disp_en, abort_now, restart;
  logic [NUM_ENG-1:0]  disp_oh, ack_oh;

  function automatic logic [ENG_W-1:0] ptr_inc(input logic [ENG_W-1:0] p);
    return (int'(p) == NUM_ENG - 1) ? '0 : p + 1'b1;
  endfunction

  // Two independent round-robin arbiters: dispatch and collect.
  always_comb begin
    elig    = NP'(disp_ready & ~eng_busy_q);
    cand    = NP'(res_valid & eng_busy_q);
    d_found = 1'b0;
    c_found = 1'b0;
    d_win   = '0;
    c_win   = '0;
    dj      = 0;
    cj      = 0;
    di      = '0;
    ci      = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      dj = int'(dptr_q) + i;
      if (dj >= NUM_ENG) dj = dj - NUM_ENG;
      di = ENG_W'(dj);
      if (!d_found && elig[di]) begin
        d_found = 1'b1;
        d_win   = di;
      end
      cj = int'(cptr_q) + i;
      if (cj >= NUM_ENG) cj = cj - NUM_ENG;
      ci = ENG_W'(cj);
      if (!c_found && cand[ci]) begin
        c_found = 1'b1;
        c_win   = ci;
      end
    end
  end

  assign last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);
  assign mid       = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
  assign drained   = (eng_busy_q == '0);
  assign abort_now = abort_q | (frame_start & mid);
  // A mid-frame restart stops dispatch at once, except for the final pixel.
  assign disp_en   = (state_q == S_DISPATCH) && d_found &&
                     (!frame_start || last_pix);
  assign restart   = ((state_q == S_IDLE) && frame_start) ||
                     ((state_q == S_DRAIN) && drained && abort_now);
  assign disp_oh   = disp_en ? (NUM_ENG'(1) << d_win) : '0;
  assign ack_oh    = c_found ? (NUM_ENG'(1) << c_win) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      eng_busy_q   <= '0;
      abort_q      <= 1'b0;
      dptr_q       <= '0;
      cptr_q       <= '0;
      for (int i = 0; i < NP; i++) addr_tab_q[i] <= '0;
      disp_valid_q <= 1'b0;
      disp_eng_q   <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      res_ack_q    <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      eng_busy_q   <= eng_busy_d;
      abort_q      <= abort_d;
      dptr_q       <= dptr_d;
      cptr_q       <= cptr_d;
      addr_tab_q   <= addr_tab_d;
      disp_valid_q <= disp_valid_d;
      disp_eng_q   <= disp_eng_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      res_ack_q    <= res_ack_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (frame_start) state_d = S_DISPATCH;
      S_DISPATCH:
        if (frame_start || (disp_en && last_pix)) state_d = S_DRAIN;
      S_DRAIN:
        if (drained) state_d = abort_now ? S_DISPATCH : S_DONE;
      S_DONE:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    abort_d    = abort_now;
    dptr_d     = dptr_q;
    cptr_d     = cptr_q;
    addr_tab_d = addr_tab_q;
    eng_busy_d = (eng_busy_q | disp_oh) & ~ack_oh;
    if ((state_q == S_DRAIN) && drained) abort_d = 1'b0;
    if (restart) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (disp_en) begin
      addr_tab_d[d_win] = addr_q;
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
      addr_d = last_pix ? '0 : addr_q + ADDR_W'(1);
    end
    if (disp_en) dptr_d = ptr_inc(d_win);
    if (c_found) cptr_d = ptr_inc(c_win);
  end

  always_comb begin
    disp_valid_d = disp_en;
    disp_eng_d   = disp_en ? d_win : '0;
    pix_x_d      = disp_en ? x_q : '0;
    pix_y_d      = disp_en ? y_q : '0;
    res_ack_d    = ack_oh;
    fb_we_d      = c_found && !abort_now;
    fb_addr_d    = fb_we_d ? addr_tab_q[c_win] : '0;
    fb_data_d    = fb_we_d ? res_iter[int'(c_win)*ITER_W +: ITER_W] : '0;
    busy_d       = (state_d == S_DISPATCH) || (state_d == S_DRAIN);
    frame_done_d = (state_q == S_DONE);
  end

  assign disp_valid = disp_valid_q;
  assign disp_eng   = disp_eng_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign res_ack    = res_ack_q;
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Bench for mandel_pixel_scheduler: engine pool model plus a pixel/write
// scoreboard built from the raster, round-robin and abort rules.
module tb_mandel_pixel_scheduler;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int NE = 2;
  localparam int EW = 1;
  localparam int IW = 8;
  localparam int AW = 3;
  localparam int NPIX = H * V;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_start = 1'b0;
  logic [NE-1:0]   disp_ready = '0;
  logic            disp_valid;
  logic [EW-1:0]   disp_eng;
  logic [15:0]     pix_x, pix_y;
  logic [NE-1:0]   res_valid = '0;
  logic [NE*IW-1:0] res_iter = '0;
  logic [NE-1:0]   res_ack;
  logic            fb_we;
  logic [AW-1:0]   fb_addr;
  logic [IW-1:0]   fb_data;
  logic            busy, frame_done;

  mandel_pixel_scheduler #(
    .H_RES(H), .V_RES(V), .NUM_ENG(NE), .ENG_W(EW), .ITER_W(IW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .disp_ready(disp_ready), .disp_valid(disp_valid), .disp_eng(disp_eng),
    .pix_x(pix_x), .pix_y(pix_y), .res_valid(res_valid), .res_iter(res_iter),
    .res_ack(res_ack), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Engine pool model
  bit            act [NE];
  int            cnt [NE];
  int            eaddr [NE];
  logic [NE-1:0] en = '0;
  logic [NE-1:0] force_rv = '0;
  bit            hold = 0;
  int            lat = 3;

  // Scoreboard
  int            exp_k, dptr, cptr, n_disp, n_wr, n_fd, n_abort_ack, wr_seq;
  int            cyc = 0, start_cyc = 0, outst_at_abort;
  logic [NE-1:0] prev_elig = '0, prev_cand = '0;
  bit            tb_abort = 0, in_order = 0, first_pending = 0;
  bit [NPIX-1:0] wmap;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NE-1:0] m, input int p);
    for (int i = 0; i < NE; i++) begin
      int j;
      j = (p + i) % NE;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  function automatic int outstanding();
    int n = 0;
    for (int i = 0; i < NE; i++) if (act[i]) n++;
    return n;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NE; i++) begin
      res_valid[i]  = (act[i] && cnt[i] == 0 && !hold) | force_rv[i];
      disp_ready[i] = en[i] & !act[i];
      res_iter[i*IW +: IW] = IW'(eaddr[i] + 10);
    end
    prev_elig = disp_ready;
    for (int i = 0; i < NE; i++) prev_cand[i] = res_valid[i] & act[i];
  endtask

  task automatic step();
    int w;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      for (int i = 0; i < NE; i++) begin
        act[i] = 0;
        cnt[i] = 0;
      end
      dptr = 0;
      cptr = 0;
      tb_abort = 0;
      drive_inputs();
      return;
    end
    if (prev_cand != '0) chk("ack_due", 32'(res_ack != '0), 1);
    if (res_ack != '0) begin
      chk("ack_onehot", $countones(res_ack), 1);
      w = rr_pick(prev_cand, cptr);
      if (w < 0) begin
        chk("ack_unexpected", 32'(res_ack), 0);
      end else begin
        chk("ack_eng", 32'(res_ack), 32'(1) << w);
        cptr = (w + 1) % NE;
        chk("wr_en", 32'(fb_we), 32'(!tb_abort));
        if (!tb_abort) begin
          chk("wr_addr", 32'(fb_addr), eaddr[w]);
          chk("wr_data", 32'(fb_data), eaddr[w] + 10);
          wmap[eaddr[w]] = 1'b1;
          n_wr++;
          if (in_order) begin
            chk("wr_order", 32'(fb_addr), wr_seq);
            wr_seq++;
          end
        end else begin
          n_abort_ack++;
        end
        act[w] = 0;
      end
    end else if (fb_we) begin
      chk("stray_we", 32'(fb_we), 0);
    end
    for (int i = 0; i < NE; i++) if (act[i] && cnt[i] > 0) cnt[i]--;
    if (disp_valid) begin
      if (tb_abort) begin
        chk("restart_drained", outstanding(), 0);
        tb_abort = 0;
        exp_k = 0;
        n_disp = 0;
        n_wr = 0;
        wr_seq = 0;
        wmap = '0;
      end
      if (first_pending) begin
        chk("start_latency", 32'((cyc - start_cyc) >= 2), 1);
        first_pending = 0;
      end
      w = rr_pick(prev_elig, dptr);
      chk("disp_eng", 32'(disp_eng), w);
      chk("pix_x", 32'(pix_x), (exp_k % NPIX) % H);
      chk("pix_y", 32'(pix_y), (exp_k % NPIX) / H);
      if (w >= 0) begin
        act[w] = 1;
        cnt[w] = lat;
        eaddr[w] = exp_k % NPIX;
        dptr = (w + 1) % NE;
      end
      exp_k++;
      n_disp++;
    end
    if (frame_done) n_fd++;
    drive_inputs();
  endtask

  task automatic start_frame();
    exp_k = 0;
    n_disp = 0;
    n_wr = 0;
    n_fd = 0;
    wr_seq = 0;
    wmap = '0;
    first_pending = 1;
    start_cyc = cyc;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic run_frame(input bit rnd, input bit do_abort,
                           input int abort_at);
    bit aborted = 0;
    bit done = 0;
    start_frame();
    for (int c = 0; c < 400 && !done; c++) begin
      if (rnd) begin
        en  = NE'($urandom_range(0, 3));
        lat = $urandom_range(1, 5);
        drive_inputs();
      end
      if (do_abort && !aborted && n_disp == abort_at && busy) begin
        aborted = 1;
        tb_abort = 1;
        n_abort_ack = 0;
        outst_at_abort = outstanding();
        frame_start = 1'b1;
      end
      step();
      frame_start = 1'b0;
      if (n_fd > 0) done = 1;
    end
    chk("frame_timeout", 32'(done), 1);
    chk("n_disp", n_disp, NPIX);
    chk("n_wr", n_wr, NPIX);
    chk("wmap", 32'(wmap), (1 << NPIX) - 1);
    if (do_abort) chk("abort_acks", n_abort_ack, outst_at_abort);
    for (int c = 0; c < 4; c++) step();
    chk("n_frame_done", n_fd, 1);
    chk("busy_low", 32'(busy), 0);
  endtask

  initial begin
    logic [NE-1:0] a1, a2;
    int c;
    for (int i = 0; i < NE; i++) begin
      act[i] = 0;
      cnt[i] = 0;
      eaddr[i] = 0;
    end
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_outs", 32'(|{disp_valid, disp_eng, pix_x, pix_y, res_ack,
                             fb_we, fb_addr, fb_data, busy, frame_done}), 0);
    end

    en = 2'b11;
    lat = 3;
    drive_inputs();
    run_frame(0, 0, 0);

    en = 2'b01;
    in_order = 1;
    drive_inputs();
    run_frame(0, 0, 0);
    in_order = 0;

    en = 2'b11;
    drive_inputs();
    run_frame(0, 1, 5);

    hold = 1;
    drive_inputs();
    start_frame();
    chk("busy_mid", 32'(busy), 1);
    c = 0;
    while (n_disp < 2 && c < 20) begin
      step();
      c++;
    end
    chk("hold_two_disp", n_disp, 2);
    repeat (5) step();
    hold = 0;
    drive_inputs();
    step();
    a1 = res_ack;
    step();
    a2 = res_ack;
    chk("sim_ack_first", $countones(a1), 1);
    chk("sim_ack_pair", 32'(a1 | a2), 3);
    c = 0;
    while (n_fd == 0 && c < 200) begin
      step();
      c++;
    end
    chk("sim_frame_done", n_fd, 1);
    chk("sim_wmap", 32'(wmap), (1 << NPIX) - 1);
    repeat (4) step();

    for (int f = 0; f < 6; f++)
      run_frame(1, (f % 2) == 1, $urandom_range(1, 6));

    en = 2'b01;
    lat = 3;
    drive_inputs();
    start_frame();
    c = 0;
    while (n_disp < 1 && c < 20) begin
      step();
      c++;
    end
    chk("rst_pre_busy", outstanding(), 1);
    rst = 1'b1;
    step();
    chk("rst_outs", 32'(|{disp_valid, disp_eng, pix_x, pix_y, res_ack,
                          fb_we, fb_addr, fb_data, busy, frame_done}), 0);
    rst = 1'b0;
    force_rv = 2'b01;
    drive_inputs();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stray_ack", 32'(res_ack), 0);
    end
    force_rv = '0;
    drive_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mandel_pixel_scheduler.md
Name: mandel_pixel_scheduler

Overview:
- Sequences one full-frame Mandelbrot render across a pool of NUM_ENG iteration engines.
- Walks the pixel raster (x fastest) and dispatches each pixel coordinate to a free engine, with round-robin arbitration.
- Collects iteration counts from engines and issues one framebuffer write per cycle.
- Restarts the frame whenever the zoom controller signals a zoom/position change. Sits between the zoom/mapping unit, the engine pool and the framebuffer.

Parameters:
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- NUM_ENG, 4, number of iteration engines (2..8).
- ENG_W, 2, width of the engine index; must satisfy 2^ENG_W >= NUM_ENG.
- ITER_W, 8, iteration-count width.
- ADDR_W, 19, framebuffer address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- frame_start  in  1  one-cycle pulse: zoom or position changed; (re)start the frame.
- disp_ready  in  NUM_ENG  per-engine idle flag.
- disp_valid  out  1  one-cycle dispatch strobe.
- disp_eng  out  ENG_W  index of the target engine for this dispatch.
- pix_x  out  16  dispatched pixel column.
- pix_y  out  16  dispatched pixel row.
- res_valid  in  NUM_ENG  per-engine result available; held until acked.
- res_iter  in  NUM_ENG*ITER_W  flattened iteration counts; engine i occupies bits [i*ITER_W +: ITER_W].
- res_ack  out  NUM_ENG  one-hot, one-cycle result acknowledge.
- fb_we  out  1  framebuffer write strobe.
- fb_addr  out  ADDR_W  write address, y*H_RES+x.
- fb_data  out  ITER_W  write data.
- busy  out  1  high in DISPATCH or DRAIN.
- frame_done  out  1  one-cycle pulse when a frame completes normally.

Behaviour:
- Reset values: all outputs are registered and reset to 0. Internal state after reset: state=IDLE, x=y=0, eng_busy=0, abort=0, dispatch RR pointer=0, collect RR pointer=0.
- States:
  - IDLE: wait for frame_start; on it, go to DISPATCH.
  - DISPATCH: issue at most one dispatch per cycle. After the dispatch of (H_RES-1, V_RES-1), go to DRAIN.
  - DRAIN: no dispatches. Leave when eng_busy==0. With abort=0, go to DONE. With abort=1, clear abort, reset x=y=0 and go to DISPATCH.
  - DONE: one cycle; frame_done=1 at the next edge; then go to IDLE.
- eng_busy[i]: internal bitmap. Set at the edge where engine i is dispatched; cleared at the edge where res_ack[i] is asserted.
- Dispatch rule:
  - Eligible engines = disp_ready & ~eng_busy, using registered eng_busy.
  - The lowest eligible index at or after the dispatch RR pointer wins. The pointer then moves to winner+1, wrapping at NUM_ENG.
  - At the next edge: disp_valid=1, disp_eng=winner, pix_x=x, pix_y=y. Also store addr_reg[winner] = y*H_RES+x.
  - x increments; at H_RES-1 it wraps to 0 and y increments.
  - No eligible engine means no dispatch and x/y hold.
- Collect rule (active in every state, including IDLE):
  - Candidates = res_valid & eng_busy. Round-robin with its own pointer selects one candidate per cycle.
  - At the next edge: res_ack=onehot(winner) and eng_busy[winner] cleared.
  - If abort=0: also fb_we=1, fb_addr=addr_reg[winner], fb_data=res_iter slice of winner.
  - res_valid with eng_busy=0 is ignored, never acked.
- Same engine in one cycle: an engine cannot be both dispatched and collected in the same cycle, because it is busy while its result is pending.
- Dispatch/collect throughput: dispatching engine A and collecting engine B in the same cycle is allowed. Throughput is 1 dispatch + 1 write per cycle.
- Latency:
  - frame_start in IDLE: the first disp_valid occurs no earlier than 2 edges later.
  - A result appearing: ack and write occur at the next edge.
- frame_start during DISPATCH or DRAIN (mid-frame):
  - Set abort=1, stop dispatching immediately, enter DRAIN.
  - Outstanding results are acked with fb_we suppressed.
  - When drained, restart at (0,0); no frame_done.
- frame_start in DONE: ignored (frame_done still pulses); a new frame needs another pulse.
- frame_start in the same cycle as the final dispatch: the final dispatch completes, abort=1 is set, and the frame restarts.
- rst mid-frame: return to IDLE, eng_busy=0, and drop all pending writes. Engines must also be reset by rst.
- Address arithmetic: y*H_RES+x is computed incrementally (+1 per dispatch), with no multiplier. The counter restarts at 0 when the frame restarts.

Test Plan (bench params H_RES=4, V_RES=2, NUM_ENG=2, ENG_W=1, ITER_W=8, ADDR_W=3):
- rst then idle 10 cycles -> all outputs 0; no disp_valid.
- frame_start, both engines always ready, each engine returns iter=addr+10 three cycles after dispatch -> 8 dispatches alternating eng 0/1 with (x,y) = (0,0),(1,0)…(3,1); 8 fb_we with fb_addr 0..7 and data 10..17; then one frame_done pulse; busy falls.
- Engine 1 disp_ready held 0 -> all 8 pixels go to eng 0 in raster order; fb_addr strictly 0..7.
- frame_start after 5 dispatches with 2 results outstanding -> no further disp_valid until both acked; those acks have fb_we=0; then restart from (0,0); 8 further writes 0..7; exactly one frame_done.
- res_valid on both engines in the same cycle -> acks on consecutive cycles in RR order; res_ack is never 2'b11.
- rst asserted while eng 0 busy -> at the next edge all outputs 0; subsequent res_valid[0] not acked.
